// File: rtl/buf_frame_data.sv
// buf_frame_data: frame-atomic buffer between the tag-detection AXI-stream
// and the MCU EBI read port. Every frame is stored as wide data entries
// followed by one trailer entry. The MCU can only see a frame once the
// trailer is written. The read side serialises entries into 16-bit words,
// least-significant word first.
module buf_frame_data #(
    parameter int    NUM_TAGS      = 10,
    parameter int    NUM_CHANNELS  = 4,
    parameter int    CHANNEL_WIDTH = 32,
    parameter int    FIFO_DEPTH    = 128,
    parameter string MODE          = "drop",
    parameter string MEMORY_TYPE   = "block",
    localparam int   DATA_WIDTH    = NUM_CHANNELS * CHANNEL_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [NUM_TAGS-1:0]   s_axis_tuser,
    input  logic                  s_axis_tlast,
    input  logic                  rd_ena,
    output logic                  rd_ready,
    output logic [15:0]           rd_data,
    output logic [15:0]           frame_count,
    output logic [15:0]           drop_count
);

    localparam int PTR_W     = $clog2(FIFO_DEPTH) + 1;
    localparam int IDX_W     = PTR_W - 1;
    localparam int WORDS     = DATA_WIDTH / 16;
    localparam int WIDX_W    = $clog2(WORDS);
    // The tag field is zero-extended to a whole EBI word, so the beat count
    // and the drop count each land in their own 16-bit word.
    localparam int TAG_SLOT  = ((NUM_TAGS + 15) / 16) * 16;
    localparam bit STALL     = (MODE == "stall");
    localparam bit USE_BLOCK = (MEMORY_TYPE == "block");

    typedef enum logic [1:0] {
        ST_ACCEPT,
        ST_TRAILER,
        ST_DISCARD
    } state_t;

    state_t                state;
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      commit_ptr;
    logic [PTR_W-1:0]      commit_vis;
    logic [PTR_W-1:0]      rd_ptr;
    logic [WIDX_W-1:0]     word_idx;
    logic [NUM_TAGS-1:0]   tag_q;
    logic [15:0]           beat_count;
    logic                  ready_en;
    logic [2:0]            rd_sync;

    // Bit DATA_WIDTH of each entry marks a trailer.
    logic [DATA_WIDTH:0]   mem [FIFO_DEPTH];
    logic [DATA_WIDTH:0]   rd_entry;
    logic [DATA_WIDTH:0]   mem_wdata;
    logic                  mem_we;
    logic [DATA_WIDTH-1:0] trailer_entry;
    logic [15:0]           entry_words [WORDS];

    logic [PTR_W-1:0]      free;
    logic [PTR_W-1:0]      uncommitted;
    logic                  free_ok;
    logic                  frame_full;
    logic                  overflow;
    logic                  tready_c;
    logic                  accept;
    logic                  pop;
    logic                  last_word;
    logic                  frame_inc;
    logic                  frame_dec;

    // Free space uses the registered read pointer. A pop in the same cycle
    // is therefore seen one cycle late, which is the safe direction.
    assign free        = PTR_W'(FIFO_DEPTH) - (wr_ptr - rd_ptr);
    assign uncommitted = wr_ptr - commit_ptr;
    assign free_ok     = (free >= PTR_W'(2));
    assign frame_full  = (uncommitted == PTR_W'(FIFO_DEPTH - 1));
    assign overflow    = !free_ok || (STALL && frame_full && !s_axis_tlast);

    // The ready level depends on the write state. In stall mode a frame that
    // fills the whole buffer must still be accepted, so that it can be
    // discarded rather than deadlock.
    always_comb begin
        tready_c = 1'b0;
        unique case (state)
            ST_ACCEPT:  tready_c = STALL ? (free_ok || frame_full) : 1'b1;
            ST_DISCARD: tready_c = 1'b1;
            default:    tready_c = 1'b0;
        endcase
    end

    assign s_axis_tready = ready_en & tready_c;
    assign accept        = s_axis_tvalid & s_axis_tready;

    // Trailer layout from the LSB: tag bitmap, beat count, drop count, zero pad.
    always_comb begin
        trailer_entry                       = '0;
        trailer_entry[NUM_TAGS-1:0]         = tag_q;
        trailer_entry[TAG_SLOT +: 16]       = beat_count;
        trailer_entry[TAG_SLOT + 16 +: 16]  = drop_count;
    end

    // Select the memory write: a data beat that fits, or the trailer.
    always_comb begin
        mem_we    = 1'b0;
        mem_wdata = {1'b0, s_axis_tdata};
        if (state == ST_TRAILER) begin
            mem_we    = 1'b1;
            mem_wdata = {1'b1, trailer_entry};
        end else if (state == ST_ACCEPT && accept && !overflow) begin
            mem_we    = 1'b1;
        end
    end

    // Entry storage is not reset. Stale contents are never visible because
    // the read side only exposes entries behind the commit pointer.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[wr_ptr[IDX_W-1:0]] <= mem_wdata;
        end
    end

    generate
        if (USE_BLOCK) begin : g_block_read
            // Synchronous read port so that the array maps onto block RAM.
            always_ff @(posedge clk) begin
                rd_entry <= mem[rd_ptr[IDX_W-1:0]];
            end
        end else begin : g_dist_read
            assign rd_entry = mem[rd_ptr[IDX_W-1:0]];
        end
    endgenerate

    // Write FSM: accept beats, write the trailer, or discard an overflowing frame.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_ACCEPT;
            wr_ptr     <= '0;
            commit_ptr <= '0;
            commit_vis <= '0;
            tag_q      <= '0;
            beat_count <= '0;
            drop_count <= '0;
            ready_en   <= 1'b0;
        end else begin
            ready_en   <= 1'b1;
            commit_vis <= commit_ptr;
            unique case (state)
                ST_ACCEPT: begin
                    if (accept) begin
                        if (!overflow) begin
                            wr_ptr <= wr_ptr + PTR_W'(1);
                            if (beat_count != 16'hFFFF) begin
                                beat_count <= beat_count + 16'd1;
                            end
                            if (s_axis_tlast) begin
                                tag_q <= s_axis_tuser;
                                state <= ST_TRAILER;
                            end
                        end else begin
                            wr_ptr     <= commit_ptr;
                            beat_count <= '0;
                            if (s_axis_tlast) begin
                                if (drop_count != 16'hFFFF) begin
                                    drop_count <= drop_count + 16'd1;
                                end
                            end else begin
                                state <= ST_DISCARD;
                            end
                        end
                    end
                end
                ST_TRAILER: begin
                    wr_ptr     <= wr_ptr + PTR_W'(1);
                    commit_ptr <= wr_ptr + PTR_W'(1);
                    beat_count <= '0;
                    state      <= ST_ACCEPT;
                end
                ST_DISCARD: begin
                    if (accept && s_axis_tlast) begin
                        if (drop_count != 16'hFFFF) begin
                            drop_count <= drop_count + 16'd1;
                        end
                        state <= ST_ACCEPT;
                    end
                end
                default: state <= ST_ACCEPT;
            endcase
        end
    end

    // The commit pointer is exposed one cycle late. This gives the
    // synchronous read port time to see a trailer written in the
    // commit cycle.
    assign rd_ready  = (commit_vis != rd_ptr);
    assign pop       = rd_sync[1] & ~rd_sync[2] & rd_ready;
    assign last_word = (word_idx == WIDX_W'(WORDS - 1));
    assign frame_inc = (state == ST_TRAILER);
    assign frame_dec = pop & last_word & rd_entry[DATA_WIDTH];

    // Split the current entry into EBI words, least-significant word first.
    always_comb begin
        for (int i = 0; i < WORDS; i++) begin
            entry_words[i] = rd_entry[i*16 +: 16];
        end
    end

    // Read side: synchronise the MCU strobe and pop one word per rising edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_sync  <= '0;
            rd_ptr   <= '0;
            word_idx <= '0;
            rd_data  <= '0;
        end else begin
            rd_sync <= {rd_sync[1:0], rd_ena};
            if (pop) begin
                rd_data <= entry_words[word_idx];
                if (last_word) begin
                    word_idx <= '0;
                    rd_ptr   <= rd_ptr + PTR_W'(1);
                end else begin
                    word_idx <= word_idx + WIDX_W'(1);
                end
            end
        end
    end

    // Committed-frame count. A commit and a final trailer read in the
    // same cycle cancel out.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            frame_count <= '0;
        end else begin
            unique case ({frame_inc, frame_dec})
                2'b10:   frame_count <= frame_count + 16'd1;
                2'b01:   frame_count <= frame_count - 16'd1;
                default: frame_count <= frame_count;
            endcase
        end
    end

endmodule
